// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller.
// Opcodes, flag bit positions and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_XOR  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_SL   = 3'd5;
    localparam logic [2:0] OP_SR   = 3'd6;
    localparam logic [2:0] OP_ZERO = 3'd7;

    localparam int F_Z = 0;
    localparam int F_N = 1;
    localparam int F_M = 2;
    localparam int F_C = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports: valid[1:0], last_id in; grant[1:0] one-hot, gid out.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_id,
    output logic [1:0] grant,
    output logic       gid
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // tie: favour whoever did not win last time
            2'b11:   grant = last_id ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign gid = grant[1];

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters (round-robin).
// Ports: req_* (2 clients), alu_* (to/from ALU), resp_* (tagged response).
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*OPW-1:0]   req_op,
    input  logic [1:0]         req_sub,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [OPW-1:0]     alu_op,
    output logic               alu_sub,
    output logic               alu_cin,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [3:0]         alu_flags,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [WIDTH-1:0]   resp_data,
    output logic [3:0]         resp_flags
);

    state_t             state;
    logic               last_id;
    logic [1:0]         grant;
    logic               gid;
    logic               accept;

    logic [OPW-1:0]     op_q;
    logic               sub_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               id_q;
    logic [WIDTH-1:0]   data_q;
    logic [3:0]         flags_q;

    rr_arb2 u_arb (
        .valid   (req_valid),
        .last_id (last_id),
        .grant   (grant),
        .gid     (gid)
    );

    // Only state gates readiness; resp_ready never reaches req_ready.
    assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            last_id <= 1'b1;
            op_q    <= OPW'(OP_ZERO);
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= gid ? req_op[OPW +: OPW]
                                       : req_op[0 +: OPW];
                        sub_q   <= req_sub[gid];
                        a_q     <= gid ? req_a[WIDTH +: WIDTH]
                                       : req_a[0 +: WIDTH];
                        b_q     <= gid ? req_b[WIDTH +: WIDTH]
                                       : req_b[0 +: WIDTH];
                        id_q    <= gid;
                        last_id <= gid;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU sees the operand registers for this whole cycle
                    data_q  <= alu_result;
                    flags_q <= alu_flags;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign alu_sub    = sub_q;
    assign alu_cin    = sub_q;

    assign resp_valid = (state == ST_RESP);
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign resp_flags = flags_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a bench-side ALU.
// Directed steps plus randomized ops against an arithmetic reference.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [1:0]  req_sub;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        alu_sub;
    logic        alu_cin;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_data;
    logic [3:0]  resp_flags;

    int tests = 0;
    int fails = 0;

    logic [2:0]  t_op[2];
    logic        t_sub[2];
    logic [31:0] t_a[2];
    logic [31:0] t_b[2];
    logic        last_w;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(32), .OPW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_sub    (req_sub),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_sub    (alu_sub),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_flags (resp_flags)
    );

    // External ALU as it would sit at the parent level
    logic [32:0] s33;
    logic [31:0] bop;
    logic [31:0] res;
    logic        cf;
    logic        mf;
    always_comb begin
        s33 = '0;
        bop = alu_sub ? ~alu_b : alu_b;
        res = '0;
        cf  = 1'b0;
        mf  = 1'b0;
        case (alu_op)
            3'd0: begin
                s33 = {1'b0, alu_a} + {1'b0, bop} + {32'b0, alu_cin};
                res = s33[31:0];
                cf  = s33[32];
                mf  = (alu_a[31] == bop[31]) && (res[31] != alu_a[31]);
            end
            3'd1:    res = alu_a ^ alu_b;
            3'd2:    res = alu_a | alu_b;
            3'd3:    res = alu_a & alu_b;
            3'd4:    res = ~(alu_a | alu_b);
            3'd5:    res = alu_a << alu_b[4:0];
            3'd6:    res = alu_a >> alu_b[4:0];
            default: res = '0;
        endcase
        alu_result = res;
        alu_flags  = {cf, mf, res[31], res == 32'd0};
    end

    // Reference: {C, M, N, Z, data} from plain integer arithmetic
    function automatic logic [35:0] ref_op(input logic [2:0] op,
                                           input logic sub,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint u;
        longint s;
        logic [31:0] r;
        logic c = 1'b0;
        logic m = 1'b0;
        case (op)
            3'd0: begin
                if (sub) begin
                    u = ua - ub;
                    s = sa - sb;
                    c = (ua >= ub);
                end else begin
                    u = ua + ub;
                    s = sa + sb;
                    c = (u > 64'sh0FFFFFFFF);
                end
                r = u[31:0];
                m = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1:    r = a ^ b;
            3'd2:    r = a | b;
            3'd3:    r = a & b;
            3'd4:    r = ~(a | b);
            3'd5:    r = a << b[4:0];
            3'd6:    r = a >> b[4:0];
            default: r = 32'd0;
        endcase
        return {c, m, r[31], r == 32'd0, r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_op  = {t_op[1], t_op[0]};
        req_sub = {t_sub[1], t_sub[0]};
        req_a   = {t_a[1], t_a[0]};
        req_b   = {t_b[1], t_b[0]};
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        last_w = 1'b1;
    endtask

    // One complete operation; called at a negedge with the DUT idle.
    task automatic run_op(input logic [1:0] v, input int hold,
                          output logic id, output logic [31:0] d,
                          output logic [3:0] f);
        logic        w;
        logic [35:0] e;
        req_valid = v;
        drive();
        #1;
        w = (v == 2'b11) ? ~last_w : v[1];
        chk("grant", req_ready, 64'(2'b01 << w));
        e = ref_op(t_op[w], t_sub[w], t_a[w], t_b[w]);
        @(negedge clk);
        last_w = w;
        chk("exec_rv", resp_valid, 0);
        chk("exec_rdy", req_ready, 0);
        chk("exec_op", alu_op, t_op[w]);
        chk("exec_a", alu_a, t_a[w]);
        chk("exec_cin", alu_cin, t_sub[w]);
        @(negedge clk);
        id = resp_id;
        d  = resp_data;
        f  = resp_flags;
        for (int h = 0; h <= hold; h++) begin
            chk("resp_rv", resp_valid, 1);
            chk("resp_id", resp_id, w);
            chk("resp_data", resp_data, e[31:0]);
            chk("resp_flags", resp_flags, e[35:32]);
            chk("resp_rdy", req_ready, 0);
            if (h == hold) resp_ready = 1'b1;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        chk("post_rv", resp_valid, 0);
    endtask

    logic        oid;
    logic [31:0] od;
    logic [3:0]  of;

    initial begin
        for (int i = 0; i < 2; i++) begin
            t_op[i] = 3'd0; t_sub[i] = 1'b0; t_a[i] = '0; t_b[i] = '0;
        end
        drive();
        do_reset();

        // reset state
        #1;
        chk("rst_rv", resp_valid, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_flags", resp_flags, 0);
        chk("rst_op", alu_op, 7);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_sub", alu_sub, 0);
        chk("rst_rdy0", req_ready, 0);
        req_valid = 2'b11;
        #1;
        chk("rst_tie", req_ready, 2'b01);
        req_valid = 2'b00;
        @(negedge clk);

        // single add
        t_op[0] = 3'd0; t_sub[0] = 1'b0; t_a[0] = 5; t_b[0] = 7;
        run_op(2'b01, 0, oid, od, of);
        chk("t1_data", od, 12);
        chk("t1_flags", of, 4'b0000);
        chk("t1_id", oid, 0);

        // subtract to zero
        t_op[1] = 3'd0; t_sub[1] = 1'b1;
        t_a[1] = 32'h10; t_b[1] = 32'h10;
        run_op(2'b10, 0, oid, od, of);
        chk("t2_data", od, 0);
        chk("t2_flags", of, 4'b1001);
        chk("t2_id", oid, 1);

        // tie fairness from reset, both held valid
        do_reset();
        t_op[0] = 3'd1; t_a[0] = 32'hAAAA; t_b[0] = 32'h0F0F;
        t_op[1] = 3'd3; t_sub[1] = 1'b0;
        t_a[1] = 32'hFFFF0000; t_b[1] = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            run_op(2'b11, 0, oid, od, of);
            chk("t3_order", oid, k % 2);
        end

        // backpressure with the other requester waiting
        run_op(2'b11, 5, oid, od, of);

        // reset while in EXEC
        req_valid = 2'b00;
        @(negedge clk);
        t_op[0] = 3'd4; t_a[0] = 32'h1; t_b[0] = 32'h2;
        req_valid = 2'b01;
        drive();
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_w = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t5_rv", resp_valid, 0);
            @(negedge clk);
        end
        chk("t5_op", alu_op, 7);
        chk("t5_a", alu_a, 0);
        chk("t5_data", resp_data, 0);
        chk("t5_id", resp_id, 0);
        t_op[0] = 3'd2; t_sub[0] = 1'b0;
        t_a[0] = 32'hF0; t_b[0] = 32'h0F;
        run_op(2'b01, 0, oid, od, of);
        chk("t5_or", od, 32'hFF);

        // shift and overflow
        t_op[0] = 3'd5; t_a[0] = 1; t_b[0] = 31;
        run_op(2'b01, 0, oid, od, of);
        chk("t6_shl", od, 32'h80000000);
        t_op[1] = 3'd0; t_sub[1] = 1'b0;
        t_a[1] = 32'h7FFFFFFF; t_b[1] = 1;
        run_op(2'b10, 0, oid, od, of);
        chk("t6_m", of[2], 1);
        chk("t6_n", of[1], 1);

        // randomized ops against the reference
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                t_op[i]  = 3'($urandom_range(0, 7));
                t_sub[i] = 1'($urandom_range(0, 1));
                t_a[i]   = $urandom;
                t_b[i]   = ($urandom_range(0, 3) == 0) ? t_a[i] : $urandom;
            end
            run_op(2'($urandom_range(1, 3)), $urandom_range(0, 2),
                   oid, od, of);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
